// File: rtl/crp16_wb_pkg.sv
// Shared types and widths for the CRP16 register-file writeback front end.
// Optional feature macro used by this block: CRP16_WB_PENDING_EN.
package crp16_wb_pkg;

    localparam int CRP16_REG_SEL_W = 3;
    localparam int CRP16_DATA_W    = 16;

    typedef struct packed {
        logic                       valid;
        logic [CRP16_REG_SEL_W-1:0] sel;
        logic [CRP16_DATA_W-1:0]    val;
    } crp16_wb_slot_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } crp16_wb_src_e;

endpackage

// File: rtl/crp16_wb_slot.sv
// One-entry holding register for a single result producer.
// Accepts a new entry whenever it is empty or being drained in the same cycle.
module crp16_wb_slot #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [DATA_W-1:0] i_val,
    input  logic              i_drain,
    output logic              o_ready,
    output logic              o_fill,
    output logic              o_valid,
    output logic [SEL_W-1:0]  o_sel,
    output logic [DATA_W-1:0] o_val
);

    logic              r_valid;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_val;

    assign o_ready = !r_valid || i_drain;
    assign o_fill  = i_valid && o_ready;
    assign o_valid = r_valid;
    assign o_sel   = r_sel;
    assign o_val   = r_val;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_val   <= '0;
        end else if (o_fill) begin
            r_valid <= 1'b1;
            r_sel   <= i_sel;
            r_val   <= i_val;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/crp16_reg_writeback.sv
// Serialises ALU and load results onto the register file's single write port, oldest first.
// Define CRP16_WB_PENDING_EN to add the per-register pending-write vector.
module crp16_reg_writeback
    import crp16_wb_pkg::*;
#(
    parameter int DATA_W = CRP16_DATA_W,
    parameter int SEL_W  = CRP16_REG_SEL_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_val,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_val,
    output logic              write,
    output logic [SEL_W-1:0]  write_sel,
    output logic [DATA_W-1:0] write_val,
    output logic              busy
`ifdef CRP16_WB_PENDING_EN
    ,
    output logic [(2**SEL_W)-1:0] pending
`endif
);

    logic              w_a_valid, w_a_fill, w_a_drain;
    logic [SEL_W-1:0]  w_a_sel;
    logic [DATA_W-1:0] w_a_val;
    logic              w_m_valid, w_m_fill, w_m_drain;
    logic [SEL_W-1:0]  w_m_sel;
    logic [DATA_W-1:0] w_m_val;
    logic              w_a_next, w_m_next;
    crp16_wb_src_e     w_src;
    logic              r_m_older;

    crp16_wb_slot #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_slot_a (
        .clock   (clock),
        .resetn  (resetn),
        .i_valid (alu_valid),
        .i_sel   (alu_sel),
        .i_val   (alu_val),
        .i_drain (w_a_drain),
        .o_ready (alu_ready),
        .o_fill  (w_a_fill),
        .o_valid (w_a_valid),
        .o_sel   (w_a_sel),
        .o_val   (w_a_val)
    );

    crp16_wb_slot #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_slot_m (
        .clock   (clock),
        .resetn  (resetn),
        .i_valid (mem_valid),
        .i_sel   (mem_sel),
        .i_val   (mem_val),
        .i_drain (w_m_drain),
        .o_ready (mem_ready),
        .o_fill  (w_m_fill),
        .o_valid (w_m_valid),
        .o_sel   (w_m_sel),
        .o_val   (w_m_val)
    );

    // Arbitration depends only on registered slot state, never on the handshake inputs.
    assign w_src     = (w_m_valid && (!w_a_valid || r_m_older)) ? SRC_MEM : SRC_ALU;
    assign w_m_drain = w_m_valid && (w_src == SRC_MEM);
    assign w_a_drain = w_a_valid && (w_src == SRC_ALU);

    assign write = w_a_valid || w_m_valid;
    assign busy  = write;

    always_comb begin
        write_sel = '0;
        write_val = '0;
        if (w_m_drain) begin
            write_sel = w_m_sel;
            write_val = w_m_val;
        end else if (w_a_drain) begin
            write_sel = w_a_sel;
            write_val = w_a_val;
        end
    end

    // A slot that is valid and not draining cannot be refilled, so "next & !fill" means retained.
    assign w_a_next = w_a_fill || (w_a_valid && !w_a_drain);
    assign w_m_next = w_m_fill || (w_m_valid && !w_m_drain);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_m_older <= 1'b1;
        end else if (w_a_next && w_m_next) begin
            if (w_a_fill && w_m_fill)
                r_m_older <= 1'b1;
            else if (w_a_fill)
                r_m_older <= 1'b1;
            else if (w_m_fill)
                r_m_older <= 1'b0;
        end else if (w_a_next) begin
            r_m_older <= 1'b0;
        end else if (w_m_next) begin
            r_m_older <= 1'b1;
        end
    end

`ifdef CRP16_WB_PENDING_EN
    always_comb begin
        pending = '0;
        if (w_a_valid) pending[w_a_sel] = 1'b1;
        if (w_m_valid) pending[w_m_sel] = 1'b1;
    end
`endif

endmodule

// File: tb/tb_crp16_reg_writeback.sv
// Scoreboard bench: the stimulus driver queues expected writes in acceptance order, the monitor checks each write.
module tb_crp16_reg_writeback;
    import crp16_wb_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [2:0]  alu_sel = '0, mem_sel = '0;
    logic [15:0] alu_val = '0, mem_val = '0;
    logic        alu_ready, mem_ready, write, busy;
    logic [2:0]  write_sel;
    logic [15:0] write_val;
`ifdef CRP16_WB_PENDING_EN
    logic [7:0]  pending;
`endif

    crp16_reg_writeback dut (
        .clock     (clock),
        .resetn    (resetn),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_sel   (alu_sel),
        .alu_val   (alu_val),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_sel   (mem_sel),
        .mem_val   (mem_val),
        .write     (write),
        .write_sel (write_sel),
        .write_val (write_val),
        .busy      (busy)
`ifdef CRP16_WB_PENDING_EN
        ,
        .pending   (pending)
`endif
    );

    always #5 clock = ~clock;

    crp16_wb_slot_t exp_q[$];
    logic [15:0]    rf [8];
    int             n_tot = 0, n_pass = 0, n_writes = 0;
    logic           last_ar, last_mr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write must match the oldest outstanding accepted result.
    always @(negedge clock) begin
        if (write) begin
            crp16_wb_slot_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("spurious_write", {13'd0, write_sel, write_val}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write_sel", {29'd0, write_sel}, {29'd0, e.sel});
                chk("write_val", {16'd0, write_val}, {16'd0, e.val});
            end
            rf[write_sel] = write_val;
        end
    end

    // One clock of stimulus; acceptance is sampled mid-cycle, MEM queued first on a tie.
    task automatic cyc(input logic av, input logic [2:0] as, input logic [15:0] ad,
                       input logic mv, input logic [2:0] ms, input logic [15:0] md,
                       output logic acc_a, output logic acc_m);
        alu_valid = av; alu_sel = as; alu_val = ad;
        mem_valid = mv; mem_sel = ms; mem_val = md;
        @(negedge clock);
        last_ar = alu_ready;
        last_mr = mem_ready;
        acc_a = av && alu_ready;
        acc_m = mv && mem_ready;
        @(posedge clock);
        #1;
        if (acc_m) exp_q.push_back('{valid: 1'b1, sel: ms, val: md});
        if (acc_a) exp_q.push_back('{valid: 1'b1, sel: as, val: ad});
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a, m;
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, a, m);
    endtask

    initial begin
        logic aa, am;
        int   ai, mi, w0, w1;
        for (int i = 0; i < 8; i++) rf[i] = 16'hFFFF;

        // Reset state
        #3;
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("rst_write_sel", {29'd0, write_sel}, 32'd0);
        chk("rst_write_val", {16'd0, write_val}, 32'd0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        idle(2);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single ALU result: written in the following cycle only
        cyc(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 16'd0, aa, am);
        chk("single_acc", {31'd0, aa}, 32'd1);
        idle(3);
        chk("single_rf5", {16'd0, rf[5]}, 32'h1234);

        // Simultaneous, same destination: MEM first, ALU value final
        cyc(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555, aa, am);
        idle(3);
        chk("tie_rf2", {16'd0, rf[2]}, 32'h0000AAAA);

        // ALU one cycle ahead of MEM to the same register: ALU older
        cyc(1'b1, 3'd3, 16'hA011, 1'b0, 3'd0, 16'd0, aa, am);
        cyc(1'b1, 3'd3, 16'hA012, 1'b1, 3'd3, 16'h5011, aa, am);
        chk("stag_mem_ready_empty", {31'd0, last_mr}, 32'd1);
        chk("stag_alu_ready_drain", {31'd0, last_ar}, 32'd1);
        idle(4);
        chk("stag_rf3", {16'd0, rf[3]}, 32'h0000A012);

        // MEM back-pressure once the ALU entry becomes older
        cyc(1'b1, 3'd3, 16'hA001, 1'b1, 3'd3, 16'h5001, aa, am);
        cyc(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'h5002, aa, am);
        chk("bp_mr_c1", {31'd0, last_mr}, 32'd1);
        cyc(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'h5003, aa, am);
        chk("bp_mr_c2", {31'd0, last_mr}, 32'd0);
        chk("bp_acc_c2", {31'd0, am}, 32'd0);
        cyc(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'h5003, aa, am);
        chk("bp_mr_c3", {31'd0, last_mr}, 32'd1);
        idle(4);
        chk("bp_rf3", {16'd0, rf[3]}, 32'h00005003);

        // Both streaming for 20 cycles: one write per cycle, 21 accepts total
        ai = 0; mi = 0; w0 = n_writes;
        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, 3'(ai), 16'hA100 + 16'(ai), 1'b1, 3'(mi + 3), 16'h5100 + 16'(mi), aa, am);
            ai += int'(aa);
            mi += int'(am);
        end
        w1 = n_writes;
        chk("stream_accepts", ai + mi, 32'd21);
        chk("stream_writes_in_window", w1 - w0, 32'd19);
        idle(4);
        chk("stream_writes_total", n_writes - w0, 32'd21);
        chk("stream_queue_empty", exp_q.size(), 32'd0);

`ifdef CRP16_WB_PENDING_EN
        cyc(1'b1, 3'd1, 16'h0101, 1'b1, 3'd6, 16'h0606, aa, am);
        chk("pending_both", {24'd0, pending}, 32'h42);
        idle(2);
        chk("pending_clear", {24'd0, pending}, 32'h0);
        idle(1);
`endif

        // Reset mid-cycle with both slots full: nothing written, nothing replayed
        cyc(1'b1, 3'd4, 16'hBEEF, 1'b1, 3'd7, 16'hCAFE, aa, am);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_write", {31'd0, write}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_alu_ready", {31'd0, alu_ready}, 32'd1);
        exp_q.delete();
        w0 = n_writes;
        @(posedge clock);
        #1 resetn = 1'b1;
        idle(4);
        chk("midrst_no_replay", n_writes - w0, 32'd0);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
